song_track_display: RTL and testbench

//  Parametrised successor to the single-note song display: stores a DEPTH-step song of

---
 rtl/song_pkg.sv | 16 +
 rtl/song_track_display_if.sv | 33 +++
 rtl/song_bin2bcd.sv | 17 +
 rtl/song_track_display.sv | 137 +++++++++++++
 tb/tb_song_track_display.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// Shared mode encodings and state constants for the song track display.
package song_pkg;

  localparam logic [2:0] MODE_EDIT   = 3'd1;
  localparam logic [2:0] MODE_REVIEW = 3'd2;
  localparam logic [2:0] MODE_PLAY   = 3'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_EDIT       = 3'd1;
  localparam state_t ST_REVIEW     = 3'd2;
  localparam state_t ST_PLAY_PAUSE = 3'd3;
  localparam state_t ST_PLAY_RUN   = 3'd4;

endpackage

// File: rtl/song_track_display_if.sv
// Control/display bundle between the button decoder (master) and the song display (slave).
interface song_track_display_if #(
  parameter int NOTE_W = 2,
  parameter int DEPTH  = 32
);
  localparam int POS_W = $clog2(DEPTH);

  logic [2:0]        mode;
  logic              toggle;
  logic              step_fwd;
  logic              step_back;
  logic              wr_en;
  logic [NOTE_W-1:0] note_in;
  logic [NOTE_W-1:0] cur_note;
  logic [NOTE_W-1:0] next_note;
  logic [POS_W-1:0]  pos;
  logic [3:0]        bcd_units;
  logic [3:0]        bcd_tens;
  logic              toggle_green;
  logic              toggle_red;
  logic              playing;

  modport master (
    output mode, toggle, step_fwd, step_back, wr_en, note_in,
    input  cur_note, next_note, pos, bcd_units, bcd_tens, toggle_green, toggle_red, playing
  );

  modport slave (
    input  mode, toggle, step_fwd, step_back, wr_en, note_in,
    output cur_note, next_note, pos, bcd_units, bcd_tens, toggle_green, toggle_red, playing
  );

endinterface

// File: rtl/song_bin2bcd.sv
// Combinational step index to two BCD digits (index is always below 100).
module song_bin2bcd #(
  parameter int W = 5
) (
  input  logic [W-1:0] bin,
  output logic [3:0]   tens,
  output logic [3:0]   units
);
  logic [6:0] val;

  always_comb begin
    val   = 7'(bin);
    tens  = 4'(val / 7'd10);
    units = 4'(val % 7'd10);
  end

endmodule

// File: rtl/song_track_display.sv
// Song storage, edit/review/playback FSM and registered display outputs for the guitar game.
// Build option: define SONG_LOOP_EN to make playback wrap from the last step back to step 0.
module song_track_display
  import song_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NOTE_W   = 2,
  parameter int TICK_DIV = 8
) (
  input logic clk,
  input logic rst,
  song_track_display_if.slave bus
);
  localparam int POS_W  = $clog2(DEPTH);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(DEPTH - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(TICK_DIV / 2);

  logic [NOTE_W-1:0] song [DEPTH];
  state_t            state, state_nxt, mode_state;
  logic [POS_W-1:0]  pos, pos_nxt, nxt_idx;
  logic [TICK_W-1:0] tick;
  logic              page;
  logic [NOTE_W-1:0] cur_q, next_q;
  logic [3:0]        tens_c, units_c, tens_q, units_q;
  logic              green_q, red_q;
  logic              run_st, in_group, tick_end, cursor_ok, play_step, play_wrap_ok;

  always_comb begin
    case (bus.mode)
      MODE_EDIT:   mode_state = ST_EDIT;
      MODE_REVIEW: mode_state = ST_REVIEW;
      MODE_PLAY:   mode_state = ST_PLAY_PAUSE;
      default:     mode_state = ST_IDLE;
    endcase
  end

  // A mode change always wins: pulses only act while the state matches the selected mode
  assign run_st    = (state == ST_PLAY_RUN);
  assign in_group  = (state == mode_state) || (run_st && mode_state == ST_PLAY_PAUSE);
  assign tick_end  = run_st && (tick == LAST_TICK);
  assign cursor_ok = in_group && (state == ST_EDIT || state == ST_REVIEW);
  assign nxt_idx   = (pos == LAST_POS) ? '0 : pos + 1'b1;

`ifdef SONG_LOOP_EN
  assign play_wrap_ok = 1'b1;
`else
  assign play_wrap_ok = (pos != LAST_POS);
`endif

  assign play_step = in_group && run_st && !bus.toggle && tick_end && play_wrap_ok;

  always_comb begin
    state_nxt = mode_state;
    if (in_group) begin
      state_nxt = state;
      if (state == ST_PLAY_PAUSE && bus.toggle)
        state_nxt = ST_PLAY_RUN;
      else if (run_st && (bus.toggle || (tick_end && !play_wrap_ok)))
        state_nxt = ST_PLAY_PAUSE;
    end
  end

  always_comb begin
    pos_nxt = pos;
    if (cursor_ok && bus.step_fwd && !bus.step_back)
      pos_nxt = nxt_idx;
    else if (cursor_ok && bus.step_back && !bus.step_fwd)
      pos_nxt = (pos == '0) ? LAST_POS : pos - 1'b1;
    else if (play_step)
      pos_nxt = nxt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pos   <= '0;
      tick  <= '0;
      page  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) song[i] <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      if (run_st && state_nxt == ST_PLAY_RUN)
        tick <= tick_end ? '0 : tick + 1'b1;
      else
        tick <= '0;
      if (state_nxt != ST_REVIEW)
        page <= 1'b0;
      else if (in_group && state == ST_REVIEW && bus.toggle)
        page <= ~page;
      if (in_group && state == ST_EDIT && bus.wr_en)
        song[pos] <= bus.note_in;
    end
  end

  song_bin2bcd #(.W(POS_W)) u_bcd (
    .bin   (pos),
    .tens  (tens_c),
    .units (units_c)
  );

  // Display registers lag the state/position registers by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= '0;
      next_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      cur_q   <= song[pos];
      next_q  <= song[nxt_idx];
      tens_q  <= tens_c;
      units_q <= units_c;
      case (state)
        ST_EDIT:       begin green_q <= 1'b1;             red_q <= 1'b0; end
        ST_REVIEW:     begin green_q <= ~page;            red_q <= page; end
        ST_PLAY_RUN:   begin green_q <= (tick < HALF_TICK); red_q <= 1'b0; end
        ST_PLAY_PAUSE: begin green_q <= 1'b0;             red_q <= 1'b1; end
        default:       begin green_q <= 1'b0;             red_q <= 1'b0; end
      endcase
    end
  end

  assign bus.cur_note     = cur_q;
  assign bus.next_note    = next_q;
  assign bus.pos          = pos;
  assign bus.bcd_tens     = tens_q;
  assign bus.bcd_units    = units_q;
  assign bus.toggle_green = green_q;
  assign bus.toggle_red   = red_q;
  assign bus.playing      = run_st;

endmodule

// File: tb/tb_song_track_display.sv
// Randomized bench for song_track_display against a step-level behavioural model of the song player.
module tb_song_track_display;
  localparam int DEPTH    = 32;
  localparam int NOTE_W   = 2;
  localparam int TICK_DIV = 8;
`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam logic [2:0] MD_IDLE   = 3'd0;
  localparam logic [2:0] MD_EDIT   = 3'd1;
  localparam logic [2:0] MD_REVIEW = 3'd2;
  localparam logic [2:0] MD_PLAY   = 3'd3;

  typedef enum int {M_IDLE, M_EDIT, M_REVIEW, M_PAUSE, M_RUN} mstate_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int compareCount = 0;
  int failCount = 0;

  int      mSong [DEPTH];
  int      mPos, mTick, mPage;
  mstate_e mState;
  int      eCur, eNext, eTens, eUnits, eGreen, eRed;

  song_track_display_if #(.NOTE_W(NOTE_W), .DEPTH(DEPTH)) bus ();

  song_track_display #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mSong[i] = 0;
    mPos = 0; mTick = 0; mPage = 0; mState = M_IDLE;
    eCur = 0; eNext = 0; eTens = 0; eUnits = 0; eGreen = 0; eRed = 0;
  endtask

  // One clock edge of the player: display values come from the song as it stood before the edge
  task automatic modelStep(input logic [2:0] md, input bit tg, input bit f, input bit b,
                           input bit w, input int nt);
    mstate_e target;
    eCur   = mSong[mPos];
    eNext  = mSong[(mPos + 1) % DEPTH];
    eTens  = mPos / 10;
    eUnits = mPos % 10;
    eGreen = 0; eRed = 0;
    case (mState)
      M_EDIT:   eGreen = 1;
      M_REVIEW: begin eGreen = 1 - mPage; eRed = mPage; end
      M_RUN:    eGreen = (mTick < TICK_DIV / 2) ? 1 : 0;
      M_PAUSE:  eRed = 1;
      default:  ;
    endcase
    case (md)
      MD_EDIT:   target = M_EDIT;
      MD_REVIEW: target = M_REVIEW;
      MD_PLAY:   target = M_PAUSE;
      default:   target = M_IDLE;
    endcase
    if (!(mState == target || (mState == M_RUN && target == M_PAUSE))) begin
      mState = target; mTick = 0; mPage = 0;
      return;
    end
    case (mState)
      M_EDIT, M_REVIEW: begin
        if (mState == M_EDIT && w) mSong[mPos] = nt;
        if (mState == M_REVIEW && tg) mPage = 1 - mPage;
        if (f && !b) mPos = (mPos + 1) % DEPTH;
        else if (b && !f) mPos = (mPos + DEPTH - 1) % DEPTH;
      end
      M_PAUSE: if (tg) begin mState = M_RUN; mTick = 0; end
      M_RUN: begin
        if (tg) begin
          mState = M_PAUSE; mTick = 0;
        end else if (mTick == TICK_DIV - 1) begin
          mTick = 0;
          if (mPos == DEPTH - 1 && !LOOP) mState = M_PAUSE;
          else mPos = (mPos + 1) % DEPTH;
        end else begin
          mTick++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkAll();
    checkOutput("pos", bus.pos, mPos);
    checkOutput("playing", bus.playing, (mState == M_RUN) ? 1 : 0);
    checkOutput("cur_note", bus.cur_note, eCur);
    checkOutput("next_note", bus.next_note, eNext);
    checkOutput("bcd_tens", bus.bcd_tens, eTens);
    checkOutput("bcd_units", bus.bcd_units, eUnits);
    checkOutput("green", bus.toggle_green, eGreen);
    checkOutput("red", bus.toggle_red, eRed);
  endtask

  task automatic applyStimulus(input logic [2:0] md, input bit tg, input bit f, input bit b,
                               input bit w, input int nt);
    bus.mode      = md;
    bus.toggle    = tg;
    bus.step_fwd  = f;
    bus.step_back = b;
    bus.wr_en     = w;
    bus.note_in   = NOTE_W'(nt);
  endtask

  task automatic runCycle(input logic [2:0] md, input bit tg, input bit f, input bit b,
                          input bit w, input int nt);
    applyStimulus(md, tg, f, b, w, nt);
    @(posedge clk);
    modelStep(md, tg, f, b, w, nt);
    @(negedge clk);
    checkAll();
  endtask

  // Called at a falling edge; reset lands between clock edges and must clear outputs at once
  task automatic resetPulse();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_pos", bus.pos, 0);
    checkOutput("rst_playing", bus.playing, 0);
    checkOutput("rst_cur", bus.cur_note, 0);
    checkOutput("rst_next", bus.next_note, 0);
    checkOutput("rst_tens", bus.bcd_tens, 0);
    checkOutput("rst_units", bus.bcd_units, 0);
    checkOutput("rst_green", bus.toggle_green, 0);
    checkOutput("rst_red", bus.toggle_red, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    checkAll();
  endtask

  initial begin
    logic [2:0] rm;
    applyStimulus(MD_IDLE, 0, 0, 0, 0, 0);
    modelReset();
    @(negedge clk);
    resetPulse();

    runCycle(MD_EDIT, 0, 0, 0, 0, 0);
    runCycle(MD_EDIT, 0, 1, 0, 1, 1);
    runCycle(MD_EDIT, 0, 1, 0, 1, 2);
    runCycle(MD_EDIT, 0, 1, 0, 1, 3);
    checkOutput("writes_pos", bus.pos, 3);
    for (int k = 0; k < 3; k++) runCycle(MD_EDIT, 0, 0, 1, 0, 0);
    runCycle(MD_EDIT, 0, 0, 0, 0, 0);
    checkOutput("song0_cur", bus.cur_note, 1);
    checkOutput("song1_next", bus.next_note, 2);
    runCycle(MD_EDIT, 0, 0, 1, 0, 0);
    checkOutput("wrap_back_pos", bus.pos, 31);
    runCycle(MD_EDIT, 0, 0, 0, 0, 0);
    checkOutput("wrap_tens", bus.bcd_tens, 3);
    checkOutput("wrap_units", bus.bcd_units, 1);
    runCycle(MD_EDIT, 0, 1, 0, 0, 0);
    checkOutput("wrap_fwd_pos", bus.pos, 0);
    runCycle(MD_EDIT, 0, 1, 1, 0, 0);

    runCycle(MD_REVIEW, 0, 0, 0, 0, 0);
    runCycle(MD_REVIEW, 0, 0, 0, 1, 3);
    runCycle(MD_REVIEW, 0, 0, 0, 0, 0);
    checkOutput("review_green", bus.toggle_green, 1);
    runCycle(MD_REVIEW, 1, 0, 0, 0, 0);
    runCycle(MD_REVIEW, 0, 0, 0, 0, 0);
    checkOutput("page_red", bus.toggle_red, 1);
    runCycle(MD_REVIEW, 1, 0, 0, 0, 0);
    runCycle(MD_REVIEW, 0, 0, 0, 0, 0);

    runCycle(MD_PLAY, 0, 0, 0, 0, 0);
    runCycle(MD_PLAY, 1, 0, 0, 0, 0);
    checkOutput("play_start", bus.playing, 1);
    for (int k = 0; k < 40; k++) runCycle(MD_PLAY, 0, 0, 0, 0, 0);
    runCycle(MD_PLAY, 1, 0, 0, 0, 0);
    runCycle(MD_PLAY, 0, 0, 0, 0, 0);
    checkOutput("pause_red", bus.toggle_red, 1);
    runCycle(MD_PLAY, 1, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) runCycle(MD_PLAY, 0, 0, 0, 0, 0);
    resetPulse();

    runCycle(MD_EDIT, 0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH && mPos != DEPTH - 2; k++)
      runCycle(MD_EDIT, 0, 0, 1, 1, $urandom_range(0, 3));
    checkOutput("boundary_pos", bus.pos, DEPTH - 2);
    runCycle(MD_PLAY, 0, 0, 0, 0, 0);
    runCycle(MD_PLAY, 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) runCycle(MD_PLAY, 0, 0, 0, 0, 0);
    checkOutput("end_pos", bus.pos, LOOP ? 0 : DEPTH - 1);
    checkOutput("end_playing", bus.playing, LOOP ? 1 : 0);
    checkOutput("end_red", bus.toggle_red, LOOP ? 0 : 1);

    rm = MD_EDIT;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) rm = 3'($urandom_range(0, 5));
      if (i == 700) resetPulse();
      runCycle(rm, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
